// File: rtl/score_controller_pkg.sv
// Shared types and constants for the vPong match sequencer.
//   DIGIT_W  width of a score digit
//   CNT_W    width of the frame timer
//   state_e  match state machine encoding
//   winner_t winner code driven to the display/logic
package score_controller_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [2:0] {
      StIdle,
      StServe,
      StPlay,
      StPaused,
      StOver
   } state_e;

   typedef logic [1:0] winner_t;

   localparam winner_t WINNER_NONE = 2'b00;
   localparam winner_t WINNER_P1   = 2'b01;
   localparam winner_t WINNER_P2   = 2'b10;

endpackage

// File: rtl/score_controller_frame_timer.sv
// Load / decrement-on-tick frame counter shared by serve timing and game-over blink.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset, clears the count
//   tick      one-cycle frame pulse; decrements a non-zero count
//   load      load load_val this cycle (wins over tick)
//   load_val  value to load
//   done      high in the cycle whose tick takes the count from 1 to 0
module score_controller_frame_timer
   import score_controller_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Depends only on the current count, so the FSM may use it to request a reload.
   assign done = tick & (count == CNT_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/score_controller.sv
// vPong match sequencer: holds both scores and runs the IDLE/SERVE/PLAY/PAUSED/OVER machine.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   frame_tick          one pulse per video frame
//   start, pause        button levels; rising edges are used
//   goal_p1, goal_p2    one-cycle goal pulses
//   point1, point2      score digits (0..WIN_SCORE)
//   ball_enable         ball may move (PLAY)
//   ball_reset          hold ball at centre (IDLE, SERVE, OVER)
//   serve_dir           0 = toward player 1, 1 = toward player 2
//   winner              00 none, 01 player 1, 10 player 2
//   blink               score display visible; toggles in OVER
module score_controller
   import score_controller_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 9,
   parameter int unsigned PAUSE_FRAMES = 60,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               pause,
   input  logic               goal_p1,
   input  logic               goal_p2,
   output logic [DIGIT_W-1:0] point1,
   output logic [DIGIT_W-1:0] point2,
   output logic               ball_enable,
   output logic               ball_reset,
   output logic               serve_dir,
   output winner_t            winner,
   output logic               blink
);

   localparam logic [DIGIT_W-1:0] WinDigit = DIGIT_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   PauseVal = CNT_W'(PAUSE_FRAMES);
   localparam logic [CNT_W-1:0]   BlinkVal = CNT_W'(BLINK_FRAMES);

   state_e             state;
   logic               start_q, pause_q;
   // Cleared by reset so a button held through reset cannot fake an edge on the first cycle.
   logic               armed;
   logic               start_edge, pause_edge;
   logic [DIGIT_W-1:0] p1_inc, p2_inc;
   logic               p1_wins, p2_wins;
   logic               timer_load, timer_done;
   logic [CNT_W-1:0]   timer_val;

   assign start_edge = start & ~start_q & armed;
   assign pause_edge = pause & ~pause_q & armed;
   assign p1_inc     = point1 + DIGIT_W'(1);
   assign p2_inc     = point2 + DIGIT_W'(1);
   assign p1_wins    = (p1_inc == WinDigit);
   assign p2_wins    = (p2_inc == WinDigit);

   // Timer loads on the same edge as the state transition it times.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = PauseVal;
      case (state)
         StIdle:  timer_load = start_edge;
         StPlay: begin
            if (goal_p1 ^ goal_p2) begin
               timer_load = 1'b1;
               if ((goal_p1 && p1_wins) || (goal_p2 && p2_wins)) timer_val = BlinkVal;
            end else if (goal_p1 && goal_p2) begin
               timer_load = 1'b1;
            end
         end
         StOver: begin
            if (start_edge) begin
               timer_load = 1'b1;
            end else if (timer_done) begin
               timer_load = 1'b1;
               timer_val  = BlinkVal;
            end
         end
         default: ;
      endcase
   end

   score_controller_frame_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (frame_tick),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
         armed       <= 1'b0;
         point1      <= '0;
         point2      <= '0;
         ball_enable <= 1'b0;
         ball_reset  <= 1'b1;
         serve_dir   <= 1'b0;
         winner      <= WINNER_NONE;
         blink       <= 1'b1;
      end else begin
         start_q <= start;
         pause_q <= pause;
         armed   <= 1'b1;
         case (state)
            StIdle: begin
               if (start_edge) begin
                  state  <= StServe;
                  point1 <= '0;
                  point2 <= '0;
                  winner <= WINNER_NONE;
               end
            end
            StServe: begin
               if (timer_done) begin
                  state       <= StPlay;
                  ball_enable <= 1'b1;
                  ball_reset  <= 1'b0;
               end
            end
            StPlay: begin
               if (goal_p1 || goal_p2) begin
                  // A goal always ends the rally, even if pause is pressed in the same cycle.
                  ball_enable <= 1'b0;
                  ball_reset  <= 1'b1;
                  state       <= StServe;
                  if (goal_p1 && !goal_p2) begin
                     point1    <= p1_inc;
                     serve_dir <= 1'b1;
                     if (p1_wins) begin
                        state  <= StOver;
                        winner <= WINNER_P1;
                     end
                  end else if (goal_p2 && !goal_p1) begin
                     point2    <= p2_inc;
                     serve_dir <= 1'b0;
                     if (p2_wins) begin
                        state  <= StOver;
                        winner <= WINNER_P2;
                     end
                  end
               end else if (pause_edge) begin
                  state       <= StPaused;
                  ball_enable <= 1'b0;
               end
            end
            StPaused: begin
               if (start_edge) begin
                  state      <= StIdle;
                  point1     <= '0;
                  point2     <= '0;
                  ball_reset <= 1'b1;
               end else if (pause_edge) begin
                  state       <= StPlay;
                  ball_enable <= 1'b1;
               end
            end
            StOver: begin
               if (start_edge) begin
                  state  <= StServe;
                  point1 <= '0;
                  point2 <= '0;
                  winner <= WINNER_NONE;
                  blink  <= 1'b1;
               end else if (timer_done) begin
                  blink <= ~blink;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with default parameters (9 / 60 / 30).
module tb_score_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, start, pause, goal_p1, goal_p2;
   logic [3:0] point1, point2;
   logic       ball_enable, ball_reset, serve_dir, blink;
   logic [1:0] winner;

   int errors = 0;
   int checks = 0;

   score_controller dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start       (start),
      .pause       (pause),
      .goal_p1     (goal_p1),
      .goal_p2     (goal_p2),
      .point1      (point1),
      .point2      (point2),
      .ball_enable (ball_enable),
      .ball_reset  (ball_reset),
      .serve_dir   (serve_dir),
      .winner      (winner),
      .blink       (blink)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic pulse_goal(input logic g1, input logic g2);
      goal_p1 = g1;
      goal_p2 = g2;
      step();
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   // From the cycle SERVE was entered: 59 ticks keep the ball held, the 60th releases it.
   task automatic serve_to_play(input string tag);
      for (int i = 0; i < 59; i++) tick_frame();
      checks++;
      if (ball_enable !== 1'b0) begin
         errors++;
         $display("FAIL %s early_release: ball_enable=%b expected 0", tag, ball_enable);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      checks++;
      if (ball_enable !== 1'b1 || ball_reset !== 1'b0) begin
         errors++;
         $display("FAIL %s release: ball_enable=%b ball_reset=%b expected 1 0", tag, ball_enable,
                  ball_reset);
      end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      {frame_tick, start, pause, goal_p1, goal_p2} = '0;
      step();
      step();
      checks++;
      if ({point1, point2} !== 8'h00) begin
         errors++;
         $display("FAIL reset_points: got %h expected 00", {point1, point2});
      end
      checks++;
      if ({ball_enable, ball_reset, serve_dir, winner, blink} !== 6'b010001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 010001",
                  {ball_enable, ball_reset, serve_dir, winner, blink});
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_serve();
      // frame_tick on the start edge must not count
      start      = 1'b1;
      frame_tick = 1'b1;
      step();
      start      = 1'b0;
      frame_tick = 1'b0;
      checks++;
      if (ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL serve_entry: ball_enable=%b ball_reset=%b expected 0 1", ball_enable,
                  ball_reset);
      end
      step();
      serve_to_play("serve");
   endtask

   task automatic test_goal_p1();
      pulse_goal(1'b1, 1'b0);
      checks++;
      if (point1 !== 4'd1 || point2 !== 4'd0) begin
         errors++;
         $display("FAIL goal_p1_score: got %0d:%0d expected 1:0", point1, point2);
      end
      checks++;
      if (serve_dir !== 1'b1 || ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL goal_p1_ctrl: dir=%b en=%b rst=%b expected 1 0 1", serve_dir, ball_enable,
                  ball_reset);
      end
      serve_to_play("after_p1");
   endtask

   task automatic test_both_goals();
      pulse_goal(1'b1, 1'b1);
      checks++;
      if (point1 !== 4'd1 || point2 !== 4'd0 || serve_dir !== 1'b1) begin
         errors++;
         $display("FAIL both_goals: got %0d:%0d dir=%b expected 1:0 dir=1", point1, point2,
                  serve_dir);
      end
      checks++;
      if (ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL both_goals_serve: en=%b rst=%b expected 0 1", ball_enable, ball_reset);
      end
      serve_to_play("replay");
   endtask

   task automatic test_pause();
      pause = 1'b1;
      step();
      pause = 1'b0;
      checks++;
      if (ball_enable !== 1'b0 || ball_reset !== 1'b0) begin
         errors++;
         $display("FAIL pause_enter: en=%b rst=%b expected 0 0", ball_enable, ball_reset);
      end
      pulse_goal(1'b1, 1'b0);
      step();
      checks++;
      if (point1 !== 4'd1 || ball_enable !== 1'b0) begin
         errors++;
         $display("FAIL pause_goal_ignored: point1=%0d en=%b expected 1 0", point1, ball_enable);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      checks++;
      if (ball_enable !== 1'b1 || ball_reset !== 1'b0) begin
         errors++;
         $display("FAIL pause_resume: en=%b rst=%b expected 1 0", ball_enable, ball_reset);
      end
      step();
      // goal and pause edge together: the goal wins
      pause   = 1'b1;
      goal_p2 = 1'b1;
      step();
      pause   = 1'b0;
      goal_p2 = 1'b0;
      checks++;
      if (point2 !== 4'd1 || serve_dir !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL goal_beats_pause: point2=%0d dir=%b rst=%b expected 1 0 1", point2,
                  serve_dir, ball_reset);
      end
      serve_to_play("after_goal_pause");
   endtask

   task automatic test_win();
      for (int i = 0; i < 7; i++) begin
         pulse_goal(1'b0, 1'b1);
         serve_to_play("climb");
      end
      checks++;
      if (point2 !== 4'd8 || winner !== 2'b00) begin
         errors++;
         $display("FAIL climb_to_8: point2=%0d winner=%b expected 8 00", point2, winner);
      end
      pulse_goal(1'b0, 1'b1);
      checks++;
      if (point2 !== 4'd9 || winner !== 2'b10 || blink !== 1'b1) begin
         errors++;
         $display("FAIL win_p2: point2=%0d winner=%b blink=%b expected 9 10 1", point2, winner,
                  blink);
      end
      checks++;
      if (ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL win_ball: en=%b rst=%b expected 0 1", ball_enable, ball_reset);
      end
      step();
      for (int i = 0; i < 29; i++) tick_frame();
      checks++;
      if (blink !== 1'b1) begin
         errors++;
         $display("FAIL blink_early: blink=%b expected 1", blink);
      end
      tick_frame();
      checks++;
      if (blink !== 1'b0) begin
         errors++;
         $display("FAIL blink_toggle: blink=%b expected 0", blink);
      end
      pulse_goal(1'b0, 1'b1);
      pulse_goal(1'b1, 1'b0);
      step();
      checks++;
      if (point2 !== 4'd9 || point1 !== 4'd1) begin
         errors++;
         $display("FAIL over_goals_ignored: got %0d:%0d expected 1:9", point1, point2);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({point1, point2} !== 8'h00 || winner !== 2'b00 || blink !== 1'b1) begin
         errors++;
         $display("FAIL restart: points=%h winner=%b blink=%b expected 00 00 1",
                  {point1, point2}, winner, blink);
      end
      step();
      serve_to_play("restart");
   endtask

   task automatic test_reset_mid_serve();
      for (int i = 0; i < 3; i++) begin
         pulse_goal(1'b1, 1'b0);
         if (i < 2) serve_to_play("p1_run");
      end
      checks++;
      if (point1 !== 4'd3 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: point1=%0d rst=%b expected 3 1", point1, ball_reset);
      end
      // async assertion between clock edges
      start = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if ({point1, point2, ball_enable, ball_reset, serve_dir, winner, blink} !== 14'b00000000010001)
      begin
         errors++;
         $display("FAIL async_reset: got %b expected 00000000010001",
                  {point1, point2, ball_enable, ball_reset, serve_dir, winner, blink});
      end
      step();
      reset = 1'b0;
      step();
      // start held high: must stay in IDLE, so 60 ticks must not release the ball
      for (int i = 0; i < 60; i++) tick_frame();
      checks++;
      if (ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
         errors++;
         $display("FAIL held_start: en=%b rst=%b expected 0 1", ball_enable, ball_reset);
      end
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      serve_to_play("repress");
   endtask

   initial begin
      test_reset();
      test_serve();
      test_goal_p1();
      test_both_goals();
      test_pause();
      test_win();
      test_reset_mid_serve();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
